fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction} pairs between fetch and decode.
// Handles redirect flush and flags misaligned fetch addresses with a sticky error bit.
module fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_address,
    input  logic [31:0]              in_instruction,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_address,
    output logic [31:0]              out_instruction,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misaligned_error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          accept;
    logic          aligned;
    logic          push;
    logic          pop;
    logic          bad;

    always_comb begin
        in_ready  = (count < FULL);
        out_valid = (count != '0);
        aligned   = (in_address[1:0] == 2'b00);
        // A misaligned fetch still completes the handshake; it is just not stored.
        accept    = in_valid & in_ready & ~flush & ~reset;
        push      = accept & aligned;
        bad       = accept & ~aligned;
        pop       = out_valid & out_ready & ~flush & ~reset;
        out_address     = '0;
        out_instruction = '0;
        if (out_valid) begin
            out_address     = mem[rd_ptr][63:32];
            out_instruction = mem[rd_ptr][31:0];
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_address, in_instruction};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            misaligned_error <= 1'b0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bad) begin
                misaligned_error <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected entries as it issues fetches,
// the monitor retires them against the DUT head each cycle.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic                   clock;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic [31:0]            in_address;
    logic [31:0]            in_instruction;
    logic                   in_ready;
    logic                   out_valid;
    logic [31:0]            out_address;
    logic [31:0]            out_instruction;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   misaligned_error;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_address       (in_address),
        .in_instruction   (in_instruction),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_address      (out_address),
        .out_instruction  (out_instruction),
        .out_ready        (out_ready),
        .count            (count),
        .misaligned_error (misaligned_error)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    ent_t q[$];
    ent_t pend_e;
    logic pend;
    logic pend_mis;
    logic exp_mis;
    logic started;
    int   passed;
    int   total;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the edge, using only bench-driven inputs.
    always @(posedge clock) begin
        started <= 1'b1;
        if (reset) begin
            q.delete();
            exp_mis = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (out_ready && q.size() != 0) begin
                void'(q.pop_front());
            end
            if (pend) begin
                q.push_back(pend_e);
            end
            if (pend_mis) begin
                exp_mis = 1'b1;
            end
        end
        pend     = 1'b0;
        pend_mis = 1'b0;
    end

    always @(negedge clock) begin
        if (started) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("misaligned_error", 64'(misaligned_error), 64'(exp_mis));
            if (q.size() != 0) begin
                chk("out_address", 64'(out_address), 64'(q[0].a));
                chk("out_instruction", 64'(out_instruction), 64'(q[0].i));
            end else begin
                chk("out_address_idle", 64'(out_address), 64'd0);
                chk("out_instruction_idle", 64'(out_instruction), 64'd0);
            end
        end
    end

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [31:0] addr, input logic ordy);
        @(posedge clock);
        #1;
        reset          = rst;
        flush          = fl;
        in_valid       = iv;
        in_address     = addr;
        in_instruction = instr_of(addr);
        out_ready      = ordy;
        pend           = 1'b0;
        pend_mis       = 1'b0;
        if (!rst && !fl && iv && q.size() < DEPTH) begin
            if (addr[1:0] == 2'b00) begin
                pend   = 1'b1;
                pend_e = '{addr, instr_of(addr)};
            end else begin
                pend_mis = 1'b1;
            end
        end
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        started        = 1'b0;
        pend           = 1'b0;
        pend_mis       = 1'b0;
        exp_mis        = 1'b0;
        reset          = 1'b1;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_address     = '0;
        in_instruction = '0;
        out_ready      = 1'b0;

        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 1);

        // Fill with decode stalled, try a fifth entry while full, then drain in order.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 32'(i * 4), 0);
        end
        step(0, 0, 1, 32'h10, 0);
        step(0, 0, 1, 32'h10, 1);
        for (int unsigned i = 0; i < DEPTH + 1; i++) begin
            step(0, 0, 0, 32'h0, 1);
        end

        // Streaming across many pointer wraps.
        for (int unsigned i = 0; i < 2 * DEPTH * DEPTH + 2; i++) begin
            step(0, 0, 1, 32'h100 + 32'(i * 4), 1);
        end
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);

        // Flush with three held entries and a concurrent fetch of 0x40.
        step(0, 0, 1, 32'h20, 0);
        step(0, 0, 1, 32'h24, 0);
        step(0, 0, 1, 32'h28, 0);
        step(0, 1, 1, 32'h40, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);

        // Misaligned fetch: flag sets, count holds, flag survives flush.
        step(0, 0, 1, 32'h50, 0);
        step(0, 0, 1, 32'h06, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 1, 32'h60, 1);
        step(0, 0, 0, 32'h0, 1);
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);

        // Reset together with flush while full.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, 32'h200 + 32'(i * 4), 0);
        end
        step(1, 1, 1, 32'h300, 1);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h304, 1);
        step(0, 0, 0, 32'h0, 1);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
